// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle for seq_divider.
//   master modport (requester): drives start, dividend, divisor; observes results.
//   slave modport  (divider)  : samples start and operands; drives quotient, remainder,
//                               busy, ready, div_zero, overflow.
// All data fields are DW+1 bits wide.
interface seq_divider_if #(
    parameter int unsigned DW = 8
);
    logic          start;
    logic [DW:0]   dividend;
    logic [DW:0]   divisor;
    logic [DW:0]   quotient;
    logic [DW:0]   remainder;
    logic          busy;
    logic          ready;
    logic          div_zero;
    logic          overflow;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, ready, div_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, ready, div_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - seq_divider_if.slave: start/dividend/divisor in; quotient/remainder/busy/
//          ready/div_zero/overflow out
// Configuration macro: DIVIDER_SIGNED_EN
//   defined   - operands are two's complement; quotient truncates toward zero, remainder
//               takes the dividend's sign, -2^DW / -1 saturates and flags overflow.
//   undefined - operands are unsigned DW+1-bit values, overflow stays 0.
// Latency: DW+3 edges from the start-sampling edge to ready; 2 edges on a zero divisor.
module seq_divider #(
    parameter int unsigned DW = 8
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);
    localparam int unsigned  W    = DW + 1;
    localparam int unsigned  CW   = $clog2(W) + 1;
    localparam logic [W-1:0] One  = W'(1);
    localparam logic [W-1:0] QMax = {1'b0, {DW{1'b1}}};
`ifdef DIVIDER_SIGNED_EN
    localparam bit SignedEn = 1'b1;
`else
    localparam bit SignedEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StInit, StSubShift, StDone} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   dq_q, dq_d;          // dividend magnitude shifting out, quotient in
    logic [W-1:0]   prem_q, prem_d;      // partial remainder
    logic [W-1:0]   dvs_q, dvs_d;        // divisor magnitude
    logic [W-1:0]   dvd_raw_q, dvd_raw_d;
    logic           q_sign_q, q_sign_d;
    logic           r_sign_q, r_sign_d;
    logic [W-1:0]   quotient_q, quotient_d;
    logic [W-1:0]   remainder_q, remainder_d;
    logic           div_zero_q, div_zero_d;
    logic           overflow_q, overflow_d;
    logic           ready_q, ready_d;

    logic [W:0]     trial;
    logic [W:0]     diff;
    logic           ge;
    logic [W-1:0]   dvd_mag;
    logic [W-1:0]   dvs_mag;

    always_comb begin
        trial   = {prem_q, dq_q[W-1]};
        diff    = trial - {1'b0, dvs_q};
        ge      = (trial >= {1'b0, dvs_q});
        dvd_mag = (SignedEn && bus.dividend[DW]) ? (~bus.dividend + One) : bus.dividend;
        dvs_mag = (SignedEn && bus.divisor[DW])  ? (~bus.divisor + One)  : bus.divisor;

        state_d     = state_q;
        cnt_d       = cnt_q;
        dq_d        = dq_q;
        prem_d      = prem_q;
        dvs_d       = dvs_q;
        dvd_raw_d   = dvd_raw_q;
        q_sign_d    = q_sign_q;
        r_sign_d    = r_sign_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;
        ready_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A start coinciding with the ready pulse is dropped.
                if (bus.start && !ready_q) state_d = StInit;
            end
            StInit: begin
                dvd_raw_d = bus.dividend;
                dq_d      = dvd_mag;
                dvs_d     = dvs_mag;
                q_sign_d  = SignedEn && (bus.dividend[DW] ^ bus.divisor[DW]);
                r_sign_d  = SignedEn && bus.dividend[DW];
                prem_d    = '0;
                cnt_d     = '0;
                state_d   = (bus.divisor == '0) ? StDone : StSubShift;
            end
            StSubShift: begin
                prem_d = ge ? diff[W-1:0] : trial[W-1:0];
                dq_d   = {dq_q[W-2:0], ge};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) state_d = StDone;
            end
            StDone: begin
                ready_d = 1'b1;
                state_d = StIdle;
                if (dvs_q == '0) begin
                    div_zero_d  = 1'b1;
                    overflow_d  = 1'b0;
                    quotient_d  = '0;
                    remainder_d = dvd_raw_q;
                end else if (SignedEn && !q_sign_q && dq_q[DW]) begin
                    // Only -2^DW / -1 lands here: positive result does not fit.
                    div_zero_d  = 1'b0;
                    overflow_d  = 1'b1;
                    quotient_d  = QMax;
                    remainder_d = '0;
                end else begin
                    div_zero_d  = 1'b0;
                    overflow_d  = 1'b0;
                    quotient_d  = q_sign_q ? (~dq_q + One) : dq_q;
                    remainder_d = r_sign_q ? (~prem_q + One) : prem_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dq_q        <= '0;
            prem_q      <= '0;
            dvs_q       <= '0;
            dvd_raw_q   <= '0;
            q_sign_q    <= 1'b0;
            r_sign_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dq_q        <= dq_d;
            prem_q      <= prem_d;
            dvs_q       <= dvs_d;
            dvd_raw_q   <= dvd_raw_d;
            q_sign_q    <= q_sign_d;
            r_sign_q    <= r_sign_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.ready     = ready_q;
    assign bus.busy      = (state_q != StIdle);
endmodule
